cv32e40p_wfi_ctrl: RTL and testbench

CV32E40P_WFI_CTRL -- requirements
Module: cv32e40p_wfi_ctrl

---
 rtl/cv32e40p_wfi_ctrl.sv | 105 ++++++++++
 tb/tb_cv32e40p_wfi_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_wfi_ctrl.sv
// WFI sequencing for the core controller: drains outstanding activity, parks the core in
// SLEEP until an enabled interrupt or debug request arrives, and counts the cycles slept.
module cv32e40p_wfi_ctrl #(
  parameter int unsigned SLEEP_CNT_WIDTH = 16
) (
  input  logic                       clk_ungated_i,
  input  logic                       rst_n,
  input  logic                       setback_i,
  input  logic                       wfi_req_i,
  input  logic                       debug_wfi_no_sleep_i,
  input  logic [31:0]                irq_pending_i,
  input  logic [31:0]                irq_enable_i,
  input  logic                       debug_req_i,
  input  logic                       if_busy_i,
  input  logic                       lsu_busy_i,
  input  logic                       apu_busy_i,
  output logic                       ctrl_busy_o,
  output logic                       wake_from_sleep_o,
  output logic                       wfi_done_o,
  output logic [SLEEP_CNT_WIDTH-1:0] sleep_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned CW = SLEEP_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wake_cond;
  logic          idle;

  // Wake ignores mstatus.MIE: a pending enabled interrupt must resume the core either way.
  assign wake_cond = (|(irq_pending_i & irq_enable_i)) | debug_req_i;
  assign idle      = ~(if_busy_i | lsu_busy_i | apu_busy_i);

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    ctrl_busy_o       = 1'b1;
    wake_from_sleep_o = 1'b0;
    wfi_done_o        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (wfi_req_i) begin
          if (debug_wfi_no_sleep_i || wake_cond) begin
            state_d = WAKE;
          end else begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (wake_cond) begin
          state_d = WAKE;
        end else if (idle) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        ctrl_busy_o       = 1'b0;
        wake_from_sleep_o = wake_cond;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (wake_cond) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        wfi_done_o = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase

    // Setback overrides every transition and counter update.
    if (setback_i) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  assign sleep_cnt_o = cnt_q;
  assign state_o     = 2'(state_q);

endmodule

// File: tb/tb_cv32e40p_wfi_ctrl.sv
// Bench for cv32e40p_wfi_ctrl: directed vector table, random stimulus against a cycle model,
// plus counter saturation and asynchronous reset sequences (wide and 4-bit counter instances).
module tb_cv32e40p_wfi_ctrl;

  typedef struct {
    logic        setback;
    logic        wfi;
    logic        nosleep;
    logic [31:0] mip;
    logic [31:0] mie;
    logic        dbg;
    logic        ifb;
    logic        lsub;
    logic        apub;
  } stim_t;

  typedef struct {
    int state;
    int busy;
    int wake;
    int done;
    int cnt;
  } expo_t;

  typedef struct {
    stim_t s;
    expo_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setback, wfi_req, no_sleep, dbg_req, if_busy, lsu_busy, apu_busy;
  logic [31:0] mip, mie;

  logic        busy_w, wake_w, done_w;
  logic [15:0] cnt_w;
  logic [1:0]  state_w;
  logic        busy_n, wake_n, done_n;
  logic [3:0]  cnt_n;
  logic [1:0]  state_n;

  int n_vec = 0;
  int n_err = 0;
  int m_state;
  int m_cnt;

  always #5 clk = ~clk;

  cv32e40p_wfi_ctrl #(.SLEEP_CNT_WIDTH(16)) u_dut (
    .clk_ungated_i(clk), .rst_n(rst_n), .setback_i(setback), .wfi_req_i(wfi_req),
    .debug_wfi_no_sleep_i(no_sleep), .irq_pending_i(mip), .irq_enable_i(mie),
    .debug_req_i(dbg_req), .if_busy_i(if_busy), .lsu_busy_i(lsu_busy), .apu_busy_i(apu_busy),
    .ctrl_busy_o(busy_w), .wake_from_sleep_o(wake_w), .wfi_done_o(done_w),
    .sleep_cnt_o(cnt_w), .state_o(state_w)
  );

  cv32e40p_wfi_ctrl #(.SLEEP_CNT_WIDTH(4)) u_dut_narrow (
    .clk_ungated_i(clk), .rst_n(rst_n), .setback_i(setback), .wfi_req_i(wfi_req),
    .debug_wfi_no_sleep_i(no_sleep), .irq_pending_i(mip), .irq_enable_i(mie),
    .debug_req_i(dbg_req), .if_busy_i(if_busy), .lsu_busy_i(lsu_busy), .apu_busy_i(apu_busy),
    .ctrl_busy_o(busy_n), .wake_from_sleep_o(wake_n), .wfi_done_o(done_n),
    .sleep_cnt_o(cnt_n), .state_o(state_n)
  );

  task automatic chk(input string nm, input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [%s] @%0t: got %0d, expected %0d", nm, tag, $time, act, exp);
    end
  endtask

  task automatic check_all(input expo_t e, input string tag);
    int cn;
    cn = (e.cnt > 15) ? 15 : e.cnt;
    chk("state", tag, int'(state_w), e.state);
    chk("ctrl_busy", tag, int'(busy_w), e.busy);
    chk("wake_from_sleep", tag, int'(wake_w), e.wake);
    chk("wfi_done", tag, int'(done_w), e.done);
    chk("sleep_cnt", tag, int'(cnt_w), e.cnt);
    chk("state_n4", tag, int'(state_n), e.state);
    chk("ctrl_busy_n4", tag, int'(busy_n), e.busy);
    chk("wake_n4", tag, int'(wake_n), e.wake);
    chk("done_n4", tag, int'(done_n), e.done);
    chk("sleep_cnt_n4", tag, int'(cnt_n), cn);
  endtask

  // Reference: spec rules over small integers; state numbers are the published state_o codes.
  function automatic bit wake_of(input stim_t s);
    return ((s.mip & s.mie) != 32'h0) || s.dbg;
  endfunction

  function automatic expo_t model_exp(input stim_t s);
    expo_t e;
    e.state = m_state;
    e.busy  = (m_state == 2) ? 0 : 1;
    e.wake  = (m_state == 2 && wake_of(s)) ? 1 : 0;
    e.done  = (m_state == 3) ? 1 : 0;
    e.cnt   = m_cnt;
    return e;
  endfunction

  task automatic model_edge(input stim_t s);
    bit w, idl;
    w   = wake_of(s);
    idl = !(s.ifb || s.lsub || s.apub);
    if (s.setback) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (m_state == 0) begin
      if (s.wfi && (s.nosleep || w)) m_state = 3;
      else if (s.wfi) begin
        m_state = 1;
        m_cnt   = 0;
      end
    end else if (m_state == 1) begin
      if (w) m_state = 3;
      else if (idl) m_state = 2;
    end else if (m_state == 2) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (w) m_state = 3;
    end else begin
      m_state = 0;
    end
  endtask

  task automatic drive(input stim_t s);
    setback  = s.setback;
    wfi_req  = s.wfi;
    no_sleep = s.nosleep;
    mip      = s.mip;
    mie      = s.mie;
    dbg_req  = s.dbg;
    if_busy  = s.ifb;
    lsu_busy = s.lsub;
    apu_busy = s.apub;
  endtask

  // One clock: drive just after posedge, check at negedge, advance the model at posedge.
  task automatic run_cycle(input stim_t s, input expo_t e, input string tag);
    drive(s);
    @(negedge clk);
    check_all(e, tag);
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  function automatic stim_t mks(input bit wfi, input bit ns, input bit dbg, input bit lsu,
                                input bit sb, input logic [31:0] p, input logic [31:0] en);
    stim_t s;
    s.setback = sb; s.wfi = wfi; s.nosleep = ns; s.mip = p; s.mie = en;
    s.dbg = dbg; s.ifb = 1'b0; s.lsub = lsu; s.apub = 1'b0;
    return s;
  endfunction

  function automatic vec_t mk(input bit wfi, input bit ns, input bit dbg, input bit lsu,
                              input bit sb, input logic [31:0] p, input logic [31:0] en,
                              input int st, input int bz, input int wk, input int dn,
                              input int cn);
    vec_t v;
    v.s = mks(wfi, ns, dbg, lsu, sb, p, en);
    v.e.state = st; v.e.busy = bz; v.e.wake = wk; v.e.done = dn; v.e.cnt = cn;
    return v;
  endfunction

  vec_t  tbl[34];
  stim_t s;
  expo_t e;

  initial begin
    //              wfi ns dbg lsu sb  mip           mie          st bz wk dn cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0, 0, 3);
    tbl[6]  = mk(1, 0, 0, 0, 0, 32'h800,      32'h800,      2, 0, 1, 0, 4);
    tbl[7]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        3, 1, 0, 1, 5);
    tbl[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 5);
    tbl[9]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 5);
    tbl[10] = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        3, 1, 0, 1, 5);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 5);
    tbl[12] = mk(1, 0, 0, 1, 0, 32'h0,        32'h0,        0, 1, 0, 0, 5);
    tbl[13] = mk(1, 0, 0, 1, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[14] = mk(1, 0, 1, 1, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 32'h0,        32'h0,        3, 1, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
    tbl[18] = mk(1, 0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        3, 1, 0, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        0, 1, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        2, 0, 0, 0, 0);
    tbl[24] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h8,        2, 0, 1, 0, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h8,        3, 1, 0, 1, 2);
    tbl[26] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 2);
    tbl[27] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 2);
    tbl[28] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[29] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
    tbl[30] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    tbl[31] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0, 0, 0);
    tbl[32] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        2, 0, 0, 0, 1);
    tbl[33] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0);

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    drive(mks(0, 0, 0, 0, 0, 32'h0, 32'h0));
    m_state = 0;
    m_cnt   = 0;
    repeat (2) @(negedge clk);
    e = model_exp(mks(0, 0, 0, 0, 0, 32'h0, 32'h0));
    check_all(e, "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_cycle(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 600; i++) begin
      s.setback = ($urandom_range(0, 49) == 0);
      s.wfi     = 1'($urandom_range(0, 1));
      s.nosleep = ($urandom_range(0, 9) == 0);
      s.dbg     = ($urandom_range(0, 19) == 0);
      s.mip     = $urandom;
      s.mie     = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      s.ifb     = ($urandom_range(0, 2) == 0);
      s.lsub    = ($urandom_range(0, 2) == 0);
      s.apub    = ($urandom_range(0, 2) == 0);
      run_cycle(s, model_exp(s), "rnd");
    end

    // Saturation: 20 SLEEP cycles pin the 4-bit counter at 15 while the wide one reads 20.
    s = mks(0, 0, 0, 0, 1, 32'h0, 32'h0);
    run_cycle(s, model_exp(s), "sat_setback");
    s = mks(1, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 22; i++) run_cycle(s, model_exp(s), "sat");
    chk("sat_cnt_wide", "sat_end", int'(cnt_w), 20);
    chk("sat_cnt_n4", "sat_end", int'(cnt_n), 15);
    chk("sat_state", "sat_end", int'(state_w), 2);

    // Asynchronous reset in SLEEP: busy returns without any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", "arst", int'(busy_w), 1);
    chk("async_state", "arst", int'(state_w), 0);
    chk("async_cnt", "arst", int'(cnt_w), 0);
    chk("async_busy_n4", "arst", int'(busy_n), 1);
    m_state = 0;
    m_cnt   = 0;
    drive(mks(0, 0, 0, 0, 0, 32'h0, 32'h0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s = mks(0, 0, 0, 0, 0, 32'h0, 32'h0);
    run_cycle(s, model_exp(s), "post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
